bcm_plane_scheduler: RTL and testbench

Sequences binary-coded-modulation refresh of the RGB LED matrix. Walks rows and the four bit-planes, and for each plane reads one row of pixels from frame memory. It drives the 2-bit plane selection into the pixel bit-plane mux, clocks the mux's R/G/B outputs into the panel shift registers, then latches and enables the row for a time weighted by plane index. It sits between the frame-buffer read port and the panel HUB75 control pins.

---
 rtl/bcm_plane_scheduler.sv | 170 +++++++++++++++++
 tb/tb_bcm_plane_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcm_plane_scheduler.sv
// bcm_plane_scheduler: binary-coded-modulation refresh sequencer for a HUB75
// RGB matrix. For every row it walks bit-planes 0..3; each plane is shifted
// out of frame memory, latched, shown for BASE_CYCLES<<plane clocks, then
// blanked for one clock before the next plane starts.
module bcm_plane_scheduler #(
  parameter  int COLS        = 64,
  parameter  int ROWS        = 32,
  parameter  int BASE_CYCLES = 8,
  localparam int COL_W       = $clog2(COLS),
  localparam int ROW_W       = $clog2(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic [ROW_W+COL_W-1:0] mem_addr,
  output logic                   mem_rd,
  output logic [1:0]             plane_sel,
  output logic                   sclk,
  output logic                   latch,
  output logic                   oe_n,
  output logic [ROW_W-1:0]       row_addr,
  output logic                   frame_done,
  output logic                   busy
);

  // Display down-counter must hold BASE_CYCLES<<3.
  localparam int CNT_W = $clog2(BASE_CYCLES * 8 + 1);
  // Shift-step index runs 0..2*COLS inclusive.
  localparam int S_W   = COL_W + 2;
  localparam logic [S_W-1:0] S_LAST = S_W'(2 * COLS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY,
    ST_BLANK
  } state_t;

  state_t                   state_q, state_d;
  logic [S_W-1:0]           s_q, s_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [1:0]               plane_q, plane_d;

  logic [ROW_W+COL_W-1:0]   mem_addr_q, mem_addr_d;
  logic                     mem_rd_q, mem_rd_d;
  logic                     sclk_q, sclk_d;
  logic                     latch_q, latch_d;
  logic                     oe_n_q, oe_n_d;
  logic [ROW_W-1:0]         row_addr_q, row_addr_d;
  logic                     frame_done_q, frame_done_d;
  logic                     busy_q, busy_d;

  // Next-state logic: sequencing of rows, planes, shift steps and display time.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    plane_d      = plane_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SHIFT;
          s_d     = '0;
          row_d   = '0;
          plane_d = 2'd0;
        end
      end
      ST_SHIFT: begin
        if (s_q == S_LAST) begin
          state_d = ST_LATCH;
        end else begin
          s_d = s_q + S_W'(1);
        end
      end
      ST_LATCH: begin
        state_d = ST_DISPLAY;
        cnt_d   = CNT_W'(BASE_CYCLES) << plane_q;
      end
      ST_DISPLAY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_BLANK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BLANK: begin
        s_d = '0;
        if (plane_q == 2'd3) begin
          plane_d      = 2'd0;
          row_d        = row_q + ROW_W'(1);  // power-of-two rows wrap naturally
          frame_done_d = (row_q == ROW_W'(ROWS - 1));
        end else begin
          plane_d = plane_q + 2'd1;
        end
        // enable only matters here, so a plane is never cut short.
        if (enable) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
          row_d   = '0;
          plane_d = 2'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every pin comes straight from a flop
  // and lines up with the state it belongs to.
  always_comb begin
    mem_rd_d   = (state_d == ST_SHIFT) && !s_d[0] && (s_d < S_LAST);
    mem_addr_d = mem_rd_d ? {row_d, s_d[COL_W:1]} : mem_addr_q;
    // Column c is read at step 2c, valid from 2c+1, clocked into the panel at 2c+2.
    sclk_d     = (state_d == ST_SHIFT) && !s_d[0] && (s_d != '0);
    latch_d    = (state_d == ST_LATCH);
    oe_n_d     = (state_d != ST_DISPLAY);
    row_addr_d = (state_d == ST_LATCH) ? row_d : row_addr_q;
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers; oe_n is preset so the panel blanks on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      cnt_q        <= '0;
      row_q        <= '0;
      plane_q      <= 2'd0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      sclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      row_addr_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      sclk_q       <= sclk_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
      row_addr_q   <= row_addr_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign plane_sel  = plane_q;  // only changes on IDLE/BLANK exit, never in SHIFT
  assign sclk       = sclk_q;
  assign latch      = latch_q;
  assign oe_n       = oe_n_q;
  assign row_addr   = row_addr_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bcm_plane_scheduler.sv
// Testbench for bcm_plane_scheduler (COLS=4, ROWS=2, BASE_CYCLES=2) with a
// 1-cycle-latency frame memory and a bit-plane mux in front of the panel.
module tb_bcm_plane_scheduler;
  localparam int C  = 4;
  localparam int R  = 2;
  localparam int B  = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [1:0]    plane_sel;
  logic          sclk, latch, oe_n;
  logic          row_addr;
  logic          frame_done, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_row_addr = 0;

  // pixel word: [3:0]=R bits, [7:4]=G bits, [11:8]=B bits, plane p = bit p
  logic [11:0] pix [0:R*C-1];
  logic [11:0] mem_dout = '0;
  logic        mux_r, mux_g, mux_b;

  bcm_plane_scheduler #(.COLS(C), .ROWS(R), .BASE_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .plane_sel(plane_sel), .sclk(sclk), .latch(latch),
    .oe_n(oe_n), .row_addr(row_addr), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // frame memory with registered read, then the bit-plane mux
  always @(posedge clk) if (mem_rd) mem_dout <= pix[mem_addr];
  assign mux_r = mem_dout[plane_sel];
  assign mux_g = mem_dout[4 + plane_sel];
  assign mux_b = mem_dout[8 + plane_sel];

  // invariants sampled on the falling edge
  logic [1:0] ps_at_start;
  logic       ra_at_start;
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (latch && (sclk || !oe_n)) begin
        n_fail++;
        $display("FAIL inv_latch t=%0t latch=%b sclk=%b oe_n=%b required latch exclusive", $time, latch, sclk, oe_n);
      end
      if (mem_rd && mem_addr[1:0] == 2'd0) begin
        ps_at_start = plane_sel;
        ra_at_start = row_addr;
      end
      if (sclk) begin
        n_checks++;
        if (plane_sel !== ps_at_start || row_addr !== ra_at_start) begin
          n_fail++;
          $display("FAIL inv_shift_stable t=%0t plane_sel=%0d row_addr=%0d required %0d/%0d",
                   $time, plane_sel, row_addr, ps_at_start, ra_at_start);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pixels();
    for (int i = 0; i < R*C; i++) pix[i] = 12'($urandom);
  endtask

  task automatic restart();
    enable = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_row_addr = 0;
    fill_pixels();
  endtask

  // Steps through one whole plane (SHIFT, LATCH, DISPLAY, BLANK) checking
  // every cycle. Entry: next edge starts SHIFT. Exit: current cycle is BLANK.
  task automatic run_plane(input int r, input int p, input bit fd0, input int drop_s,
                           input int exp_disp, output int tot);
    logic       exp_rd, exp_sclk, exp_fd;
    logic [AW-1:0] ea;
    logic [11:0] px;
    logic [2:0]  exp_rgb;
    int          disp;
    tot = 0;
    for (int s = 0; s <= 2*C; s++) begin
      tick(); tot++;
      exp_rd   = (s % 2 == 0) && (s < 2*C);
      exp_sclk = (s % 2 == 0) && (s >= 2);
      exp_fd   = (s == 0) ? fd0 : 1'b0;
      n_checks++;
      if (mem_rd !== exp_rd || sclk !== exp_sclk || latch !== 1'b0 || oe_n !== 1'b1 ||
          busy !== 1'b1 || frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL shift_ctl r=%0d p=%0d s=%0d got rd=%b sclk=%b latch=%b oe_n=%b busy=%b fd=%b required rd=%b sclk=%b latch=0 oe_n=1 busy=1 fd=%b",
                 r, p, s, mem_rd, sclk, latch, oe_n, busy, frame_done, exp_rd, exp_sclk, exp_fd);
      end
      n_checks++;
      if (plane_sel !== 2'(p) || row_addr !== 1'(exp_row_addr)) begin
        n_fail++;
        $display("FAIL shift_sel r=%0d p=%0d s=%0d got plane_sel=%0d row_addr=%0d required %0d/%0d",
                 r, p, s, plane_sel, row_addr, p, exp_row_addr);
      end
      if (exp_rd) begin
        ea = AW'(r*C + s/2);
        n_checks++;
        if (mem_addr !== ea) begin
          n_fail++;
          $display("FAIL shift_addr r=%0d p=%0d s=%0d got %0d required %0d", r, p, s, mem_addr, ea);
        end
      end
      if (exp_sclk) begin
        px = pix[r*C + (s-2)/2];
        exp_rgb = {px[8+p], px[4+p], px[p]};
        n_checks++;
        if ({mux_b, mux_g, mux_r} !== exp_rgb) begin
          n_fail++;
          $display("FAIL shift_data r=%0d p=%0d col=%0d got bgr=%b required %b", r, p, (s-2)/2, {mux_b, mux_g, mux_r}, exp_rgb);
        end
      end
      if (s == drop_s) enable = 1'b0;
    end
    // LATCH
    tick(); tot++;
    exp_row_addr = r;
    n_checks++;
    if (latch !== 1'b1 || oe_n !== 1'b1 || sclk !== 1'b0 || mem_rd !== 1'b0 || row_addr !== 1'(r)) begin
      n_fail++;
      $display("FAIL latch r=%0d p=%0d got latch=%b oe_n=%b sclk=%b rd=%b row_addr=%0d required 1/1/0/0/%0d",
               r, p, latch, oe_n, sclk, mem_rd, row_addr, r);
    end
    // DISPLAY: measure oe_n low run
    disp = 0;
    tick(); tot++;
    while (oe_n === 1'b0 && disp < 64) begin
      disp++;
      n_checks++;
      if (latch !== 1'b0 || sclk !== 1'b0 || mem_rd !== 1'b0 || plane_sel !== 2'(p) || row_addr !== 1'(r)) begin
        n_fail++;
        $display("FAIL display_ctl r=%0d p=%0d got latch=%b sclk=%b rd=%b plane_sel=%0d row_addr=%0d required 0/0/0/%0d/%0d",
                 r, p, latch, sclk, mem_rd, plane_sel, row_addr, p, r);
      end
      tick(); tot++;
    end
    n_checks++;
    if (disp != exp_disp) begin
      n_fail++;
      $display("FAIL display_len r=%0d p=%0d got %0d required %0d", r, p, disp, exp_disp);
    end
    // BLANK
    n_checks++;
    if (oe_n !== 1'b1 || latch !== 1'b0 || sclk !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL blank r=%0d p=%0d got oe_n=%b latch=%b sclk=%b busy=%b required 1/0/0/1", r, p, oe_n, latch, sclk, busy);
    end
  endtask

  task automatic check_idle(input string name, input bit exp_fd);
    n_checks++;
    if (busy !== 1'b0 || oe_n !== 1'b1 || mem_rd !== 1'b0 || sclk !== 1'b0 || latch !== 1'b0 ||
        plane_sel !== 2'd0 || frame_done !== exp_fd) begin
      n_fail++;
      $display("FAIL %s got busy=%b oe_n=%b rd=%b sclk=%b latch=%b plane_sel=%0d fd=%b required 0/1/0/0/0/0/%b",
               name, busy, oe_n, mem_rd, sclk, latch, plane_sel, frame_done, exp_fd);
    end
  endtask

  task automatic test_reset();
    int guard;
    restart();
    n_checks++;
    if (mem_addr !== '0 || row_addr !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals got addr=%0d row_addr=%0d fd=%b required 0/0/0", mem_addr, row_addr, frame_done);
    end
    check_idle("reset_idle", 1'b0);
    enable = 1'b1;
    guard = 0;
    while (oe_n !== 1'b0 && guard < 50) begin tick(); guard++; end
    n_checks++;
    if (oe_n !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_reach_display got oe_n=%b required 0 within 50 cycles", oe_n);
    end
    repeat ($urandom_range(0, 1)) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (oe_n !== 1'b1 || busy !== 1'b0 || mem_addr !== '0 || row_addr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got oe_n=%b busy=%b addr=%0d row_addr=%0d required 1/0/0/0", oe_n, busy, mem_addr, row_addr);
    end
    check_idle("reset_async_idle", 1'b0);
    tick();
    check_idle("reset_held", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_start got busy=%b rd=%b addr=%0d required 1/1/0", busy, mem_rd, mem_addr);
    end
  endtask

  task automatic test_shift();
    int tot;
    restart();
    enable = 1'b1;
    run_plane(0, 0, 1'b0, -1, B, tot);
  endtask

  task automatic test_plane_weights();
    int tot, sum;
    int wt[4]   = '{2, 4, 8, 16};
    int ptot[4] = '{13, 15, 19, 27};
    restart();
    enable = 1'b1;
    sum = 0;
    for (int p = 0; p < 4; p++) begin
      run_plane(0, p, 1'b0, -1, wt[p], tot);
      sum += tot;
      n_checks++;
      if (tot != ptot[p]) begin
        n_fail++;
        $display("FAIL plane_total p=%0d got %0d required %0d", p, tot, ptot[p]);
      end
    end
    n_checks++;
    if (sum != 74) begin
      n_fail++;
      $display("FAIL row_total got %0d required 74", sum);
    end
  endtask

  task automatic test_frame_wrap();
    int tot, sum;
    restart();
    enable = 1'b1;
    for (int f = 0; f < 2; f++) begin
      sum = 0;
      for (int r = 0; r < R; r++)
        for (int p = 0; p < 4; p++) begin
          run_plane(r, p, (f > 0 && r == 0 && p == 0), -1, B << p, tot);
          sum += tot;
        end
      n_checks++;
      if (sum != 148) begin
        n_fail++;
        $display("FAIL frame_total f=%0d got %0d required 148", f, sum);
      end
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b1 || busy !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL frame_pulse got fd=%b busy=%b rd=%b addr=%0d required 1/1/1/0", frame_done, busy, mem_rd, mem_addr);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_pulse_width got fd=%b required 0", frame_done);
    end
  endtask

  task automatic test_enable_drop();
    int tot;
    restart();
    enable = 1'b1;
    run_plane(0, 0, 1'b0, -1, B, tot);
    run_plane(0, 1, 1'b0, $urandom_range(0, 2*C), B << 1, tot);
    tick();
    check_idle("drop_idle", 1'b0);
    repeat (3) tick();
    check_idle("drop_idle_hold", 1'b0);
    // restart from row 0 plane 0, then drop during the last plane of the frame
    enable = 1'b1;
    for (int r = 0; r < R; r++)
      for (int p = 0; p < 4; p++)
        run_plane(r, p, 1'b0, (r == R-1 && p == 3) ? int'($urandom_range(0, 2*C)) : -1, B << p, tot);
    tick();
    check_idle("drop_frame_done_idle", 1'b1);
    tick();
    check_idle("drop_after_pulse", 1'b0);
  endtask

  initial begin
    test_reset();
    test_shift();
    test_plane_weights();
    test_frame_wrap();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog: any hang ends the run with a visible failure
  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
